// File: rtl/ee_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ee_access_arbiter
// Brief    : Shares the EEPROM array port between POR loader, IIC and SPI,
//            sequencing array read/write timing for each granted request.
// Revision : 1.0  initial release
// ============================================================================
module ee_access_arbiter #(
    parameter int VS_CYC     = 4,
    parameter int RD_CYC     = 2,
    parameter int WB_TIMEOUT = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        por_cfg_done,
    input  logic        por_req,
    input  logic [15:0] por_addr,
    output logic        por_ack,
    input  logic        iic_req,
    input  logic        iic_we,
    input  logic [15:0] iic_addr,
    input  logic [37:0] iic_wdata,
    output logic        iic_ack,
    input  logic        spi_req,
    input  logic        spi_we,
    input  logic [15:0] spi_addr,
    input  logic [37:0] spi_wdata,
    output logic        spi_ack,
    output logic [37:0] rdata,
    output logic        err,
    output logic [1:0]  owner,
    output logic [15:0] ee_addr,
    output logic        clr_dl,
    output logic        vs_en,
    output logic        rd_en,
    output logic        wr_start,
    output logic [37:0] if_data_out,
    input  logic        ee_wbusy,
    input  logic [37:0] ee_rdata
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_CLR   = 3'd1;
    localparam logic [2:0] c_VS    = 3'd2;
    localparam logic [2:0] c_RD    = 3'd3;
    localparam logic [2:0] c_CAP   = 3'd4;
    localparam logic [2:0] c_WR    = 3'd5;
    localparam logic [2:0] c_WBUSY = 3'd6;
    localparam logic [2:0] c_ACK   = 3'd7;

    localparam logic [1:0] c_OWN_NONE = 2'd0;
    localparam logic [1:0] c_OWN_POR  = 2'd1;
    localparam logic [1:0] c_OWN_IIC  = 2'd2;
    localparam logic [1:0] c_OWN_SPI  = 2'd3;

    localparam int                 c_CNT_W   = $clog2(VS_CYC + RD_CYC + WB_TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_VS_LAST = c_CNT_W'(VS_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_RD_LAST = c_CNT_W'(RD_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_WB_LAST = c_CNT_W'(WB_TIMEOUT - 1);

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [1:0]         r_owner;
    logic [1:0]         r_mask;
    logic [15:0]        r_addr;
    logic               r_we;
    logic [37:0]        r_wdata;
    logic [37:0]        r_rdata;
    logic               r_err;
    logic               r_seen;
    logic               r_last_spi;

    logic               w_por_ok;
    logic               w_iic_ok;
    logic               w_spi_ok;
    logic [1:0]         w_grant;
    logic               w_g_we;
    logic [15:0]        w_g_addr;
    logic [37:0]        w_g_wdata;
    logic               w_wb_done;
    logic               w_wb_tmo;

    // r_mask blocks the requester acked last cycle for one IDLE cycle
    always_comb begin
        w_por_ok  = por_req & ~por_cfg_done & (r_mask != c_OWN_POR);
        w_iic_ok  = iic_req &  por_cfg_done & (r_mask != c_OWN_IIC);
        w_spi_ok  = spi_req &  por_cfg_done & (r_mask != c_OWN_SPI);
        w_grant   = c_OWN_NONE;
        w_g_we    = 1'b0;
        w_g_addr  = 16'd0;
        w_g_wdata = 38'd0;
        if (w_por_ok)
            w_grant = c_OWN_POR;
        else if (w_iic_ok && w_spi_ok)
            w_grant = r_last_spi ? c_OWN_IIC : c_OWN_SPI;
        else if (w_iic_ok)
            w_grant = c_OWN_IIC;
        else if (w_spi_ok)
            w_grant = c_OWN_SPI;
        case (w_grant)
            c_OWN_POR: w_g_addr = por_addr;
            c_OWN_IIC: begin
                w_g_we    = iic_we;
                w_g_addr  = iic_addr;
                w_g_wdata = iic_wdata;
            end
            c_OWN_SPI: begin
                w_g_we    = spi_we;
                w_g_addr  = spi_addr;
                w_g_wdata = spi_wdata;
            end
            default: ;
        endcase
    end

    assign w_wb_done = r_seen & ~ee_wbusy;
    assign w_wb_tmo  = (r_cnt == c_WB_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (w_grant != c_OWN_NONE) w_next = w_g_we ? c_WR : c_CLR;
            c_CLR:   w_next = c_VS;
            c_VS:    if (r_cnt == c_VS_LAST) w_next = c_RD;
            c_RD:    if (r_cnt == c_RD_LAST) w_next = c_CAP;
            c_CAP:   w_next = c_ACK;
            c_WR:    w_next = c_WBUSY;
            c_WBUSY: if (w_wb_done || w_wb_tmo) w_next = c_ACK;
            c_ACK:   w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_cnt      <= '0;
            r_owner    <= c_OWN_NONE;
            r_mask     <= c_OWN_NONE;
            r_addr     <= 16'd0;
            r_we       <= 1'b0;
            r_wdata    <= 38'd0;
            r_rdata    <= 38'd0;
            r_err      <= 1'b0;
            r_seen     <= 1'b0;
            r_last_spi <= 1'b1;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state || r_state == c_IDLE) ? '0 : r_cnt + 1'b1;
            r_mask  <= (r_state == c_ACK) ? r_owner : c_OWN_NONE;
            if (r_state == c_IDLE && w_grant != c_OWN_NONE) begin
                r_owner <= w_grant;
                r_addr  <= w_g_addr;
                r_we    <= w_g_we;
                r_wdata <= w_g_wdata;
                r_err   <= 1'b0;
                r_seen  <= 1'b0;
                if (w_grant == c_OWN_IIC) r_last_spi <= 1'b0;
                if (w_grant == c_OWN_SPI) r_last_spi <= 1'b1;
            end
            if (r_state == c_ACK) r_owner <= c_OWN_NONE;
            if (r_state == c_CAP) r_rdata <= ee_rdata;
            if (r_state == c_WBUSY && ee_wbusy) r_seen <= 1'b1;
            if (r_state == c_WBUSY && !w_wb_done && w_wb_tmo) r_err <= 1'b1;
        end
    end

    assign clr_dl      = (r_state == c_CLR);
    assign vs_en       = (r_state == c_VS) || (r_state == c_RD);
    assign rd_en       = (r_state == c_RD);
    assign wr_start    = (r_state == c_WR);
    assign por_ack     = (r_state == c_ACK) && (r_owner == c_OWN_POR);
    assign iic_ack     = (r_state == c_ACK) && (r_owner == c_OWN_IIC);
    assign spi_ack     = (r_state == c_ACK) && (r_owner == c_OWN_SPI);
    assign owner       = r_owner;
    assign rdata       = r_rdata;
    assign err         = r_err;
    assign ee_addr     = (r_state != c_IDLE) ? r_addr : 16'd0;
    assign if_data_out = (r_we && (r_state == c_WR || r_state == c_WBUSY || r_state == c_ACK))
                         ? r_wdata : 38'd0;

endmodule
`default_nettype wire

// File: tb/tb_ee_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ee_access_arbiter
// Brief    : Randomized self-checking bench for ee_access_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_ee_access_arbiter;

    localparam int VS = 4;
    localparam int RD = 2;
    localparam int WB = 32;
    localparam logic [1:0] H_POR = 2'd1;
    localparam logic [1:0] H_IIC = 2'd2;
    localparam logic [1:0] H_SPI = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        por_cfg_done, por_req, por_ack;
    logic [15:0] por_addr;
    logic        iic_req, iic_we, iic_ack;
    logic [15:0] iic_addr;
    logic [37:0] iic_wdata;
    logic        spi_req, spi_we, spi_ack;
    logic [15:0] spi_addr;
    logic [37:0] spi_wdata;
    logic [37:0] rdata, if_data_out, ee_rdata;
    logic        err, clr_dl, vs_en, rd_en, wr_start, ee_wbusy;
    logic [1:0]  owner;
    logic [15:0] ee_addr;

    ee_access_arbiter #(.VS_CYC(VS), .RD_CYC(RD), .WB_TIMEOUT(WB)) dut (
        .clk(clk), .rst(rst), .por_cfg_done(por_cfg_done),
        .por_req(por_req), .por_addr(por_addr), .por_ack(por_ack),
        .iic_req(iic_req), .iic_we(iic_we), .iic_addr(iic_addr), .iic_wdata(iic_wdata), .iic_ack(iic_ack),
        .spi_req(spi_req), .spi_we(spi_we), .spi_addr(spi_addr), .spi_wdata(spi_wdata), .spi_ack(spi_ack),
        .rdata(rdata), .err(err), .owner(owner), .ee_addr(ee_addr),
        .clr_dl(clr_dl), .vs_en(vs_en), .rd_en(rd_en), .wr_start(wr_start),
        .if_data_out(if_data_out), .ee_wbusy(ee_wbusy), .ee_rdata(ee_rdata)
    );

    always #5 clk = ~clk;

    logic [101:0] obs;
    assign obs = {clr_dl, vs_en, rd_en, wr_start, por_ack, iic_ack, spi_ack,
                  owner, ee_addr, if_data_out, err, rdata};

    int          total = 0;
    int          bad   = 0;
    logic [37:0] m_rdata;
    logic        m_last_spi;

    function automatic logic [37:0] rnd38();
        return 38'({$urandom(), $urandom()});
    endfunction

    // Waits for a grant, then checks every cycle against the expected access timeline.
    task automatic run_txn(input logic [1:0] host, input logic we, input logic [15:0] addr,
                           input logic [37:0] wdata, input logic [37:0] rdat, input int d,
                           input int len, input logic stuck, input string tag);
        int           waited;
        int           ack_k;
        logic         exp_err;
        logic [101:0] exp;
        waited = 0;
        while (owner == 2'd0 && waited < 80) begin
            @(posedge clk); #1;
            waited++;
        end
        total++;
        if (owner !== host) begin
            bad++;
            $display("FAIL %s grant: owner=%0d expected=%0d", tag, owner, host);
            iic_req = 1'b0; spi_req = 1'b0; por_req = 1'b0;
            return;
        end
        ee_rdata = rdat;
        ack_k    = we ? (stuck ? WB + 1 : d + len + 1) : VS + RD + 2;
        exp_err  = we && stuck;
        for (int k = 0; k <= ack_k; k++) begin
            ee_wbusy = we && !stuck && k >= d && k < d + len;
            exp = {(!we && k == 0), (!we && k >= 1 && k <= VS + RD), (!we && k >= VS + 1 && k <= VS + RD),
                   (we && k == 0), (k == ack_k && host == H_POR), (k == ack_k && host == H_IIC),
                   (k == ack_k && host == H_SPI), host, addr, (we ? wdata : 38'd0),
                   (k == ack_k ? exp_err : 1'b0), ((!we && k == ack_k) ? rdat : m_rdata)};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL %s cycle %0d: got=%h expected=%h", tag, k, obs, exp);
            end
            if (k < ack_k) begin
                @(posedge clk); #1;
            end
        end
        case (host)
            H_POR:   por_req = 1'b0;
            H_IIC:   iic_req = 1'b0;
            default: spi_req = 1'b0;
        endcase
        ee_wbusy = 1'b0;
        if (!we) m_rdata = rdat;
        if (host == H_IIC) m_last_spi = 1'b0;
        if (host == H_SPI) m_last_spi = 1'b1;
        @(posedge clk); #1;
        exp = {7'd0, 2'd0, 16'd0, 38'd0, exp_err, m_rdata};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s idle: got=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; por_cfg_done = 1'b0; por_req = 1'b0; por_addr = 16'd0;
        iic_req = 1'b0; iic_we = 1'b0; iic_addr = 16'd0; iic_wdata = 38'd0;
        spi_req = 1'b0; spi_we = 1'b0; spi_addr = 16'd0; spi_wdata = 38'd0;
        ee_wbusy = 1'b0; ee_rdata = 38'd0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (obs !== 102'd0) begin
            bad++;
            $display("FAIL reset: got=%h expected=0", obs);
        end
        rst = 1'b0;
        m_rdata = 38'd0;
        m_last_spi = 1'b1;
    endtask

    task automatic test_por_read();
        logic [15:0] a;
        logic [37:0] r;
        iic_req = 1'b1; iic_we = 1'b0; iic_addr = 16'h0100;
        for (int i = 0; i < 4; i++) begin
            a = (i == 0) ? 16'h0010 : 16'($urandom());
            r = (i == 0) ? 38'h15A5A5A5A5 : rnd38();
            por_addr = a;
            por_req  = 1'b1;
            run_txn(H_POR, 1'b0, a, 38'd0, r, 0, 0, 1'b0, "por_read");
        end
    endtask

    task automatic test_gating();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            total++;
            if (owner !== 2'd0) begin
                bad++;
                $display("FAIL gating_hold: owner=%0d expected=0", owner);
            end
        end
        por_cfg_done = 1'b1;
        @(posedge clk); #1;
        total++;
        if (owner !== H_IIC) begin
            bad++;
            $display("FAIL gating_grant: owner=%0d expected=%0d", owner, H_IIC);
        end
        run_txn(H_IIC, 1'b0, 16'h0100, 38'd0, rnd38(), 0, 0, 1'b0, "gating_read");
    endtask

    task automatic test_round_robin();
        logic [1:0] pat;
        logic [1:0] win;
        logic       stuck;
        for (int it = 0; it < 14; it++) begin
            pat = (it < 3) ? 2'd3 : 2'($urandom_range(1, 3));
            iic_we = 1'($urandom()); iic_addr = 16'($urandom()); iic_wdata = rnd38();
            spi_we = 1'($urandom()); spi_addr = 16'($urandom()); spi_wdata = rnd38();
            por_req = 1'($urandom()); por_addr = 16'($urandom());
            iic_req = pat[0];
            spi_req = pat[1];
            win = (pat == 2'd3) ? (m_last_spi ? H_IIC : H_SPI) : (pat == 2'd1 ? H_IIC : H_SPI);
            stuck = ($urandom_range(0, 5) == 0);
            if (win == H_IIC)
                run_txn(H_IIC, iic_we, iic_addr, iic_wdata, rnd38(), $urandom_range(1, 3),
                        $urandom_range(1, 10), stuck, "rr_iic");
            else
                run_txn(H_SPI, spi_we, spi_addr, spi_wdata, rnd38(), $urandom_range(1, 3),
                        $urandom_range(1, 10), stuck, "rr_spi");
        end
        iic_req = 1'b0; spi_req = 1'b0; por_req = 1'b0;
    endtask

    task automatic test_spi_write();
        spi_we = 1'b1; spi_addr = 16'($urandom()); spi_wdata = 38'h2000000001;
        spi_req = 1'b1;
        run_txn(H_SPI, 1'b1, spi_addr, 38'h2000000001, rnd38(), 2, 10, 1'b0, "spi_write");
    endtask

    task automatic test_iic_timeout();
        iic_we = 1'b1; iic_addr = 16'($urandom()); iic_wdata = rnd38();
        iic_req = 1'b1;
        run_txn(H_IIC, 1'b1, iic_addr, iic_wdata, rnd38(), 0, 0, 1'b1, "iic_timeout");
        iic_we = 1'b0; iic_addr = 16'($urandom());
        iic_req = 1'b1;
        run_txn(H_IIC, 1'b0, iic_addr, 38'd0, rnd38(), 0, 0, 1'b0, "err_clear");
    endtask

    task automatic test_holdoff();
        iic_we = 1'b0; iic_addr = 16'($urandom());
        iic_req = 1'b1;
        run_txn(H_IIC, 1'b0, iic_addr, 38'd0, rnd38(), 0, 0, 1'b0, "holdoff_first");
        iic_req = 1'b1;
        @(posedge clk); #1;
        total++;
        if (owner !== 2'd0) begin
            bad++;
            $display("FAIL holdoff_mask: owner=%0d expected=0", owner);
        end
        @(posedge clk); #1;
        total++;
        if (owner !== H_IIC) begin
            bad++;
            $display("FAIL holdoff_regrant: owner=%0d expected=%0d", owner, H_IIC);
        end
        run_txn(H_IIC, 1'b0, iic_addr, 38'd0, rnd38(), 0, 0, 1'b0, "holdoff_second");
    endtask

    task automatic test_reset_mid();
        int waited;
        iic_we = 1'b0; iic_addr = 16'($urandom());
        iic_req = 1'b1;
        ee_rdata = rnd38();
        waited = 0;
        while (owner == 2'd0 && waited < 80) begin
            @(posedge clk); #1;
            waited++;
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        total++;
        if (vs_en !== 1'b1 || owner !== H_IIC) begin
            bad++;
            $display("FAIL mid_pre: vs_en=%b owner=%0d expected vs_en=1 owner=%0d", vs_en, owner, H_IIC);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if (obs !== 102'd0) begin
            bad++;
            $display("FAIL mid_reset: got=%h expected=0", obs);
        end
        rst = 1'b0;
        m_rdata = 38'd0;
        m_last_spi = 1'b1;
        spi_we = 1'b0; spi_addr = 16'($urandom());
        spi_req = 1'b1;
        run_txn(m_last_spi ? H_IIC : H_SPI, 1'b0, m_last_spi ? iic_addr : spi_addr, 38'd0,
                rnd38(), 0, 0, 1'b0, "post_reset");
        spi_req = 1'b0;
        iic_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_por_read();
        test_gating();
        test_round_robin();
        test_spi_write();
        test_iic_timeout();
        test_holdoff();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
